turn_scheduler: RTL and testbench
=================================

// Module: turn_scheduler
// PURPOSE
//   Round-robin turn scheduler for the multi-player game. Owns the single shared
//   tile comparator and hands it to one player at a time: waits for the active
//   player's key, launches a compare, keeps or passes the turn on the result,
//   enforces a per-turn timeout and latches the winner. Sits between the per-player
//   debounced key pulses and the board/compare datapath.
// PARAMETERS
//   NUM_PLAYERS  4         number of player slots (2..8)
//   PLAYER_W     2         index width, = clog2(NUM_PLAYERS)
//   TIMEOUT_CYC  50000000  cycles allowed per key press (1 s at 50 MHz), >= 2
//   TIMEOUT_W    26        timer width, must hold TIMEOUT_CYC
// PORTS
//   CLK            in   1            system clock, rising edge
//   RST_N          in   1            asynchronous active-low reset
//   rand_done      in   1            board shuffle complete (level); starts a game
//   player_en      in   NUM_PLAYERS  enabled-player mask, sampled when leaving IDLE
//   key            in   NUM_PLAYERS  one-cycle debounced key pulse per player
//   cmp_done       in   1            comparator result valid (one-cycle pulse)
//   cmp_match      in   1            picked tile matched; qualified by cmp_done
//   win            in   1            match reached finish; qualified by cmp_done&cmp_match
//   restart        in   1            one-cycle pulse: abandon game, return to IDLE
//   cmp_start      out  1            one-cycle pulse: launch compare for active_player
//   active_player  out  PLAYER_W     index of player holding the turn
//   turn_valid     out  1            1 only in WAIT_KEY (active player may press)
//   timeout_pulse  out  1            one-cycle pulse when turn expires
//   game_over      out  1            1 in DONE
//   winner         out  PLAYER_W     winning player index, valid while game_over
// BEHAVIOUR
//   Reset (RST_N=0, async): state=IDLE; all outputs 0; en mask, timer cleared.
//   All outputs registered. States: IDLE, WAIT_KEY, COMPARE, DONE.
//   IDLE: rand_done=1 and player_en!=0 -> latch mask, active_player = lowest set
//     bit, timer=0, -> WAIT_KEY. player_en==0 -> stay IDLE.
//   WAIT_KEY: turn_valid=1; timer increments each cycle.
//     key[active_player]=1 -> cmp_start=1 next cycle, -> COMPARE (latency 1).
//     keys of other players ignored (no effect, no error).
//     timer==TIMEOUT_CYC-1 with no key -> timeout_pulse=1, pass turn (see NEXT).
//     key and timeout in same cycle -> key wins, no timeout_pulse.
//   COMPARE: cmp_start high exactly one cycle; wait for cmp_done, no timeout.
//     cmp_done&cmp_match&win -> winner=active_player, game_over=1, -> DONE.
//     cmp_done&cmp_match&!win -> same player keeps turn, timer=0, -> WAIT_KEY.
//     cmp_done&!cmp_match -> pass turn (NEXT).
//   NEXT (not a state; done on the transition): active_player = next set bit of
//     latched mask above current, wrapping NUM_PLAYERS-1 -> 0; single enabled
//     player gets the turn again; timer=0; -> WAIT_KEY.
//   DONE: hold winner/game_over; ignore key, cmp_done, rand_done.
//   cmp_done outside COMPARE ignored. key pulses in IDLE/COMPARE/DONE dropped.
//   restart=1 in any state -> IDLE next cycle, outputs cleared as on reset;
//     restart outranks every other event in that cycle.
//   Timer saturates never: cleared on every turn start, so no wrap occurs.
//   Mask changes on player_en mid-game have no effect until next IDLE exit.
// TESTING
//   1 Reset mid-COMPARE: assert RST_N=0 -> outputs 0 immediately, state IDLE;
//     late cmp_done after release ignored.
//   2 player_en=4'b1010, rand_done=1 -> active_player=1, turn_valid=1; key[1]
//     -> cmp_start one cycle later, single-cycle; cmp_done&!match -> active=3;
//     next miss -> active=1 (wrap skips 0 and 2).
//   3 Match without win: active stays 1, timer restarts; key[0],key[3] pulses in
//     WAIT_KEY ignored, no cmp_start.
//   4 TIMEOUT_CYC=8: no key for 8 cycles -> timeout_pulse on cycle 8, turn
//     passes; key[active] exactly on cycle 8 -> cmp_start, no timeout_pulse.
//   5 cmp_done&match&win for player 3 -> game_over=1, winner=3, held under key
//     and cmp_done; restart pulse -> IDLE, game_over=0, winner=0.
//   6 Single enabled player 4'b0100 with misses -> active_player stays 2.

Source files
------------

// File: rtl/turn_scheduler.sv
// Purpose: round-robin owner of the shared tile comparator; hands turns between enabled players.
// Latency: key -> cmp_start one cycle; cmp_done -> next turn/winner one cycle; all outputs registered.
// Backpressure: none; key pulses outside the active player's WAIT_KEY turn are dropped.
module turn_scheduler #(
    parameter int unsigned NUM_PLAYERS = 4,
    parameter int unsigned PLAYER_W    = 2,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned TIMEOUT_W   = 26
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   rand_done,
    input  logic [NUM_PLAYERS-1:0] player_en,
    input  logic [NUM_PLAYERS-1:0] key,
    input  logic                   cmp_done,
    input  logic                   cmp_match,
    input  logic                   win,
    input  logic                   restart,
    output logic                   cmp_start,
    output logic [PLAYER_W-1:0]    active_player,
    output logic                   turn_valid,
    output logic                   timeout_pulse,
    output logic                   game_over,
    output logic [PLAYER_W-1:0]    winner
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_KEY = 2'd1,
        S_COMPARE  = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_PLAYERS-1:0] mask_q, mask_d;
    logic [TIMEOUT_W-1:0]   timer_q, timer_d;
    logic [PLAYER_W-1:0]    active_q, active_d;
    logic [PLAYER_W-1:0]    winner_q, winner_d;
    logic                   cmp_start_q, cmp_start_d;
    logic                   turn_valid_q, turn_valid_d;
    logic                   timeout_q, timeout_d;
    logic                   game_over_q, game_over_d;

    localparam logic [TIMEOUT_W-1:0] TIMER_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    // Lowest enabled slot; used to pick the opening player.
    function automatic logic [PLAYER_W-1:0] first_player(input logic [NUM_PLAYERS-1:0] mask);
        logic [PLAYER_W-1:0] sel;
        sel = '0;
        for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
            if (mask[PLAYER_W'(i - 1)]) sel = PLAYER_W'(i - 1);
        end
        return sel;
    endfunction

    // Next enabled slot above cur, wrapping; the last probe lands on cur itself
    // so a lone enabled player simply gets the turn back.
    function automatic logic [PLAYER_W-1:0] next_player(input logic [NUM_PLAYERS-1:0] mask,
                                                        input logic [PLAYER_W-1:0]    cur);
        logic [PLAYER_W-1:0] sel;
        logic [PLAYER_W-1:0] idx;
        logic                found;
        sel   = cur;
        found = 1'b0;
        for (int unsigned i = 1; i <= NUM_PLAYERS; i++) begin
            idx = PLAYER_W'((32'(cur) + i) % NUM_PLAYERS);
            if (!found && mask[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    // Next-state and registered-output computation; restart overrides everything.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        timer_d     = timer_q;
        active_d    = active_q;
        winner_d    = winner_q;
        game_over_d = game_over_q;
        cmp_start_d = 1'b0;
        timeout_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rand_done && (player_en != '0)) begin
                    mask_d   = player_en;
                    active_d = first_player(player_en);
                    timer_d  = '0;
                    state_d  = S_WAIT_KEY;
                end
            end
            S_WAIT_KEY: begin
                timer_d = timer_q + TIMEOUT_W'(1);
                // A key landing on the final timer cycle still counts as in time.
                if (key[active_q]) begin
                    cmp_start_d = 1'b1;
                    state_d     = S_COMPARE;
                end else if (timer_q == TIMER_LAST) begin
                    timeout_d = 1'b1;
                    active_d  = next_player(mask_q, active_q);
                    timer_d   = '0;
                end
            end
            S_COMPARE: begin
                if (cmp_done) begin
                    if (cmp_match && win) begin
                        winner_d    = active_q;
                        game_over_d = 1'b1;
                        state_d     = S_DONE;
                    end else if (cmp_match) begin
                        timer_d = '0;
                        state_d = S_WAIT_KEY;
                    end else begin
                        active_d = next_player(mask_q, active_q);
                        timer_d  = '0;
                        state_d  = S_WAIT_KEY;
                    end
                end
            end
            S_DONE: begin
                state_d = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (restart) begin
            state_d     = S_IDLE;
            mask_d      = '0;
            timer_d     = '0;
            active_d    = '0;
            winner_d    = '0;
            game_over_d = 1'b0;
            cmp_start_d = 1'b0;
            timeout_d   = 1'b0;
        end

        turn_valid_d = (state_d == S_WAIT_KEY);
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            timer_q      <= '0;
            active_q     <= '0;
            winner_q     <= '0;
            game_over_q  <= 1'b0;
            cmp_start_q  <= 1'b0;
            timeout_q    <= 1'b0;
            turn_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            timer_q      <= timer_d;
            active_q     <= active_d;
            winner_q     <= winner_d;
            game_over_q  <= game_over_d;
            cmp_start_q  <= cmp_start_d;
            timeout_q    <= timeout_d;
            turn_valid_q <= turn_valid_d;
        end
    end

    assign cmp_start     = cmp_start_q;
    assign active_player = active_q;
    assign turn_valid    = turn_valid_q;
    assign timeout_pulse = timeout_q;
    assign game_over     = game_over_q;
    assign winner        = winner_q;

endmodule

// File: tb/tb_turn_scheduler.sv
// Purpose: directed-vector bench for turn_scheduler with a short turn timeout.
// Latency: outputs sampled 1 ns after each rising edge.
// Backpressure: not applicable; inputs driven one cycle at a time.
module tb_turn_scheduler;

    logic       CLK;
    logic       RST_N;
    logic       rand_done;
    logic [3:0] player_en;
    logic [3:0] key;
    logic       cmp_done;
    logic       cmp_match;
    logic       win;
    logic       restart;
    logic       cmp_start;
    logic [1:0] active_player;
    logic       turn_valid;
    logic       timeout_pulse;
    logic       game_over;
    logic [1:0] winner;

    int n_vec = 0;
    int n_err = 0;

    turn_scheduler #(
        .NUM_PLAYERS(4),
        .PLAYER_W   (2),
        .TIMEOUT_CYC(8),
        .TIMEOUT_W  (4)
    ) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .rand_done    (rand_done),
        .player_en    (player_en),
        .key          (key),
        .cmp_done     (cmp_done),
        .cmp_match    (cmp_match),
        .win          (win),
        .restart      (restart),
        .cmp_start    (cmp_start),
        .active_player(active_player),
        .turn_valid   (turn_valid),
        .timeout_pulse(timeout_pulse),
        .game_over    (game_over),
        .winner       (winner)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Compact snapshot: {cmp_start, turn_valid, timeout_pulse, game_over, active, winner}
    function automatic logic [31:0] snap();
        return {24'd0, cmp_start, turn_valid, timeout_pulse, game_over, active_player, winner};
    endfunction

    function automatic logic [31:0] mk(input logic cs, input logic tv, input logic to,
                                       input logic go, input logic [1:0] ap, input logic [1:0] wn);
        return {24'd0, cs, tv, to, go, ap, wn};
    endfunction

    initial begin
        RST_N = 1'b0; rand_done = 1'b0; player_en = '0; key = '0;
        cmp_done = 1'b0; cmp_match = 1'b0; win = 1'b0; restart = 1'b0;
        tick(); tick();
        check_vec("reset_outputs", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));
        RST_N = 1'b1;

        // rand_done with no enabled player keeps the scheduler idle
        rand_done = 1'b1; player_en = 4'b0000;
        tick();
        check_vec("idle_empty_mask", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));

        // Game with players 1 and 3
        player_en = 4'b1010;
        tick();
        check_vec("start_1010", snap(), mk(0, 1, 0, 0, 2'd1, 2'd0));
        rand_done = 1'b0;
        key = 4'b0010;
        tick();
        check_vec("key1_cmp_start", snap(), mk(1, 0, 0, 0, 2'd1, 2'd0));
        key = 4'b0000;
        tick();
        check_vec("cmp_start_single", snap(), mk(0, 0, 0, 0, 2'd1, 2'd0));
        cmp_done = 1'b1; cmp_match = 1'b0;
        tick();
        check_vec("miss_to_p3", snap(), mk(0, 1, 0, 0, 2'd3, 2'd0));
        cmp_done = 1'b0;
        key = 4'b1000;
        tick();
        check_vec("key3_cmp_start", snap(), mk(1, 0, 0, 0, 2'd3, 2'd0));
        key = 4'b0000;
        tick();
        cmp_done = 1'b1;
        tick();
        check_vec("miss_wrap_to_p1", snap(), mk(0, 1, 0, 0, 2'd1, 2'd0));
        cmp_done = 1'b0;

        // Match without win keeps player 1 and restarts the turn timer
        key = 4'b0010;
        tick();
        key = 4'b0000;
        tick();
        cmp_done = 1'b1; cmp_match = 1'b1; win = 1'b0;
        tick();
        check_vec("match_keeps_p1", snap(), mk(0, 1, 0, 0, 2'd1, 2'd0));
        cmp_done = 1'b0; cmp_match = 1'b0;
        key = 4'b1001;
        tick();
        check_vec("other_keys_ignored", snap(), mk(0, 1, 0, 0, 2'd1, 2'd0));
        key = 4'b0000;
        for (int i = 2; i <= 7; i++) tick();
        check_vec("no_timeout_cycle7", snap(), mk(0, 1, 0, 0, 2'd1, 2'd0));
        tick();
        check_vec("timeout_cycle8", snap(), mk(0, 1, 1, 0, 2'd3, 2'd0));
        tick();
        check_vec("timeout_single", snap(), mk(0, 1, 0, 0, 2'd3, 2'd0));

        // Key on the final cycle of a turn beats the timeout
        for (int i = 2; i <= 7; i++) tick();
        check_vec("p3_cycle7_waiting", snap(), mk(0, 1, 0, 0, 2'd3, 2'd0));
        key = 4'b1000;
        tick();
        check_vec("key_on_cycle8", snap(), mk(1, 0, 0, 0, 2'd3, 2'd0));
        key = 4'b0000;

        // Winning match for player 3
        cmp_done = 1'b1; cmp_match = 1'b1; win = 1'b1;
        tick();
        check_vec("win_p3", snap(), mk(0, 0, 0, 1, 2'd3, 2'd3));
        cmp_match = 1'b0; win = 1'b0; key = 4'b1000; rand_done = 1'b1;
        tick();
        check_vec("done_hold", snap(), mk(0, 0, 0, 1, 2'd3, 2'd3));
        cmp_done = 1'b0; key = 4'b0000;
        restart = 1'b1;
        tick();
        check_vec("restart_clears", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));
        // restart outranks rand_done while idle
        tick();
        check_vec("restart_outranks", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));
        restart = 1'b0; rand_done = 1'b0;
        tick();

        // Single enabled player keeps the turn after misses; mid-game mask change ignored
        player_en = 4'b0100; rand_done = 1'b1;
        tick();
        check_vec("single_start_p2", snap(), mk(0, 1, 0, 0, 2'd2, 2'd0));
        rand_done = 1'b0; player_en = 4'b1111;
        for (int r = 0; r < 2; r++) begin
            key = 4'b0100;
            tick();
            key = 4'b0000;
            cmp_done = 1'b1; cmp_match = 1'b0;
            tick();
            cmp_done = 1'b0;
            check_vec("single_miss_p2", snap(), mk(0, 1, 0, 0, 2'd2, 2'd0));
        end

        // Asynchronous reset in the middle of a compare
        key = 4'b0100;
        tick();
        key = 4'b0000;
        check_vec("pre_reset_compare", snap(), mk(1, 0, 0, 0, 2'd2, 2'd0));
        #2;
        RST_N = 1'b0;
        #1;
        check_vec("async_reset_now", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));
        tick();
        RST_N = 1'b1;
        cmp_done = 1'b1; cmp_match = 1'b1; win = 1'b1;
        tick();
        check_vec("late_cmp_done_ignored", snap(), mk(0, 0, 0, 0, 2'd0, 2'd0));
        cmp_done = 1'b0; cmp_match = 1'b0; win = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
